// File: rtl/weight_stream_memory.sv
// Weight store for one neuron: DEPTH weights loaded one word at a time, streamed back
// LANES words per beat from a synchronous-read RAM, plus a separately held bias word.
module weight_stream_memory #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int ROWS  = DEPTH / LANES,
    parameter int ROW_W = $clog2(ROWS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     load_ready,
    input  logic                     rd_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     out_last,
    output logic [WIDTH-1:0]         bias_out,
    output logic                     loaded,
    output logic                     busy,
    output logic                     err
);

    localparam int ADDR_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ROW_BITS = LANES * WIDTH;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        IDLE,
        STREAM
    } state_t;

    state_t              r_state;
    logic                r_load_ready;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_loaded;
    logic                r_busy;
    logic                r_err;
    logic [WIDTH-1:0]    r_bias;
    logic [ROW_W-1:0]    r_ld_row;
    logic [LANE_W-1:0]   r_ld_lane;
    logic [ADDR_W-1:0]   r_rd_row;
    logic [ROW_BITS-1:0] r_rd_data;
    logic [ROW_BITS-1:0] r_mem [ROWS];

    logic                w_ld_fire;
    logic                w_word_fire;
    logic                w_lane_full;
    logic                w_bias_word;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ROW_BITS-1:0] w_wr_row;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_beat_fire;

    assign w_ld_fire   = (r_state == LOADING) && load_valid && r_load_ready && !load_start && !rst;
    assign w_bias_word = (r_ld_row == ROW_W'(ROWS));
    assign w_word_fire = w_ld_fire && !w_bias_word;
    assign w_lane_full = (r_ld_lane == LANE_W'(LANES - 1));
    assign w_wr_addr   = r_ld_row[ADDR_W-1:0];
    assign w_beat_fire = r_out_valid && out_ready;

    // Lower lanes are staged until the top lane arrives, so the RAM only sees full-row writes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_lane_buf
            logic [WIDTH-1:0] r_lane;
            always_ff @(posedge clk) begin
                if (w_word_fire && r_ld_lane == LANE_W'(gi)) begin
                    r_lane <= load_data;
                end
            end
            assign w_wr_row[gi*WIDTH +: WIDTH] = r_lane;
        end
    endgenerate
    assign w_wr_row[(LANES-1)*WIDTH +: WIDTH] = load_data;

    always_ff @(posedge clk) begin
        if (w_word_fire && w_lane_full) begin
            r_mem[w_wr_addr] <= w_wr_row;
        end
    end

    // Re-reading the current row while stalled keeps out_data stable without a skid buffer.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_rd_row;
        if (r_state == IDLE) begin
            w_rd_en   = rd_start && !load_start;
            w_rd_addr = '0;
        end else if (r_state == STREAM) begin
            w_rd_en   = !(w_beat_fire && r_out_last);
            w_rd_addr = w_beat_fire ? (r_rd_row + ADDR_W'(1)) : r_rd_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_load_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_loaded     <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_bias       <= '0;
            r_ld_row     <= '0;
            r_ld_lane    <= '0;
            r_rd_row     <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (load_start) begin
                        r_state      <= LOADING;
                        r_ld_row     <= '0;
                        r_ld_lane    <= '0;
                        r_loaded     <= 1'b0;
                        r_load_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end else if (rd_start) begin
                        r_err <= 1'b1;
                    end
                end
                LOADING: begin
                    if (rd_start) begin
                        r_err <= 1'b1;
                    end
                    if (load_start) begin
                        r_ld_row  <= '0;
                        r_ld_lane <= '0;
                    end else if (w_ld_fire) begin
                        if (w_bias_word) begin
                            r_bias       <= load_data;
                            r_state      <= IDLE;
                            r_load_ready <= 1'b0;
                            r_loaded     <= 1'b1;
                            r_busy       <= 1'b0;
                        end else if (w_lane_full) begin
                            r_ld_lane <= '0;
                            r_ld_row  <= r_ld_row + ROW_W'(1);
                        end else begin
                            r_ld_lane <= r_ld_lane + LANE_W'(1);
                        end
                    end
                end
                IDLE: begin
                    if (load_start) begin
                        r_state      <= LOADING;
                        r_ld_row     <= '0;
                        r_ld_lane    <= '0;
                        r_loaded     <= 1'b0;
                        r_load_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end else if (rd_start) begin
                        r_state     <= STREAM;
                        r_rd_row    <= '0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (ROWS == 1);
                        r_busy      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (load_start) begin
                        r_err <= 1'b1;
                    end
                    if (w_beat_fire) begin
                        if (r_out_last) begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_rd_row   <= r_rd_row + ADDR_W'(1);
                            r_out_last <= ((r_rd_row + ADDR_W'(1)) == ADDR_W'(ROWS - 1));
                        end
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_data   = r_rd_data;
    assign bias_out   = r_bias;
    assign loaded     = r_loaded;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_weight_stream_memory.sv
// Self-checking bench for weight_stream_memory: table-driven load/stream vectors with a
// beat scoreboard, plus hand-written error, reset-abort and reload-restart sequences.
module tb_weight_stream_memory;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int LANES = 2;
    localparam int ROWS  = DEPTH / LANES;

    logic                   clk;
    logic                   rst;
    logic                   load_start;
    logic                   load_valid;
    logic [WIDTH-1:0]       load_data;
    logic                   load_ready;
    logic                   rd_start;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_last;
    logic [WIDTH-1:0]       bias_out;
    logic                   loaded;
    logic                   busy;
    logic                   err;

    weight_stream_memory #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .rd_start   (rd_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .bias_out   (bias_out),
        .loaded     (loaded),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*WIDTH-1:0] data;
        logic                   last;
    } beat_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] bias;
        logic [7:0]  ready_pat;
        logic [31:0] exp_beat0;
        logic [15:0] exp_bias;
    } vec_t;

    beat_t       sb_q[$];
    beat_t       mon_b;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_beats = 0;
    logic [15:0] mdl_w [DEPTH];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    vec_t        vecs [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beats are compared just before the edge on which the handshake completes.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (prev_stall) begin
                chk("stall_data_stable", out_data, prev_data);
                chk("stall_last_stable", out_last, prev_last);
            end
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h with empty scoreboard", out_data);
                end else begin
                    mon_b = sb_q.pop_front();
                    chk("beat_data", out_data, mon_b.data);
                    chk("beat_last", out_last, mon_b.last);
                    n_beats++;
                end
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_beats(input int nrows);
        beat_t b;
        for (int r = 0; r < nrows; r++) begin
            for (int l = 0; l < LANES; l++) begin
                b.data[l*WIDTH +: WIDTH] = mdl_w[r*LANES + l];
            end
            b.last = (r == ROWS - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        rd_start   = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_words(input logic [15:0] base, input logic [15:0] bias,
                              input int nwords, input bit gaps);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_ready_on_start", load_ready, 1);
        chk("loaded_cleared", loaded, 0);
        chk("busy_loading", busy, 1);
        for (int k = 0; k < nwords; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_data  = (k < DEPTH) ? base + 16'(k + 1) : bias;
            tick();
        end
        load_valid = 1'b0;
        if (nwords == DEPTH + 1) begin
            for (int k = 0; k < DEPTH; k++) mdl_w[k] = base + 16'(k + 1);
            chk("loaded_set", loaded, 1);
            chk("load_ready_done", load_ready, 0);
            chk("bias_out", bias_out, bias);
            chk("busy_after_load", busy, 0);
        end
    endtask

    task automatic run_stream(input logic [7:0] pat, input int inject_at,
                              input logic [31:0] exp_beat0);
        int cyc;
        n_beats = 0;
        push_beats(ROWS);
        out_ready = 1'b0;
        rd_start  = 1'b1;
        chk("valid_before_accept", out_valid, 0);
        tick();
        rd_start = 1'b0;
        chk("first_valid_latency", out_valid, 1);
        chk("first_beat_data", out_data, exp_beat0);
        chk("busy_stream", busy, 1);
        cyc = 0;
        while (out_valid && cyc < 200) begin
            out_ready  = pat[cyc % 8];
            load_start = (cyc == inject_at);
            tick();
            load_start = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        chk("stream_in_budget", (cyc < 200), 1);
        chk("beats_total", n_beats, ROWS);
        chk("queue_drained", sb_q.size(), 0);
        chk("out_last_low_after", out_last, 0);
        chk("busy_after_stream", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{base: 16'h0000, bias: 16'h4000, ready_pat: 8'hFF,
                    exp_beat0: 32'h0002_0001, exp_bias: 16'h4000};
        vecs[1] = '{base: 16'h0100, bias: 16'h1234, ready_pat: 8'b0100_1001,
                    exp_beat0: 32'h0102_0101, exp_bias: 16'h1234};
        vecs[2] = '{base: 16'hA000, bias: 16'hFFFF, ready_pat: 8'b1011_0010,
                    exp_beat0: 32'hA002_A001, exp_bias: 16'hFFFF};

        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        rd_start   = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;

        chk("rst_load_ready", load_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_bias_out", bias_out, 0);

        // Stream request with nothing loaded.
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("no_valid_when_empty", out_valid, 0);
            tick();
        end
        chk("err_rd_in_empty", err, 1);
        do_reset();
        chk("err_cleared_by_rst", err, 0);

        for (int i = 0; i < 3; i++) begin
            load_words(vecs[i].base, vecs[i].bias, DEPTH + 1, (i % 2) == 1);
            chk("tbl_bias_out", bias_out, vecs[i].exp_bias);
            load_valid = 1'b1;
            load_data  = 16'hDEAD;
            tick();
            tick();
            load_valid = 1'b0;
            chk("idle_load_valid_ignored", load_ready, 0);
            run_stream(vecs[i].ready_pat, -1, vecs[i].exp_beat0);
            chk("tbl_no_err", err, 0);
        end

        // load_start while streaming is refused and flagged.
        load_words(16'h0300, 16'h2222, DEPTH + 1, 1'b0);
        run_stream(8'hFF, 1, 32'h0302_0301);
        chk("err_load_in_stream", err, 1);
        chk("loaded_kept", loaded, 1);
        chk("bias_kept", bias_out, 16'h2222);
        do_reset();

        // Reset after three beats aborts the stream.
        load_words(16'h0500, 16'h3333, DEPTH + 1, 1'b0);
        n_beats = 0;
        push_beats(3);
        rd_start = 1'b1;
        tick();
        rd_start  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_loaded", loaded, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_bias_out", bias_out, 0);
        chk("abort_beats", n_beats, 3);
        chk("abort_queue_empty", sb_q.size(), 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("no_valid_before_reload", out_valid, 0);
            tick();
        end
        chk("err_rd_after_abort", err, 1);

        // Partial load, then restart with a full fresh set.
        load_words(16'h0700, 16'h5555, 5, 1'b0);
        chk("partial_not_loaded", loaded, 0);
        chk("partial_busy", busy, 1);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("no_valid_while_loading", out_valid, 0);
        load_words(16'h0900, 16'h6666, DEPTH + 1, 1'b1);
        run_stream(8'b0100_1001, -1, 32'h0902_0901);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weight_stream_memory.md
WEIGHT_STREAM_MEMORY -- requirements
Module: weight_stream_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of Q2.14 weights per neuron.
REQ-002 SHALL have parameter WIDTH, default 16: weight and bias word width.
REQ-003 SHALL have parameter LANES, default 4: weights delivered per output beat; DEPTH divisible by LANES.
REQ-004 SHALL have parameter ROWS, default DEPTH/LANES (derived); ROW_W default $clog2(ROWS+1) (derived).
REQ-005 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports load_start in 1 (pulse: begin reload), load_valid in 1, load_data in WIDTH, load_ready out 1.
REQ-008 SHALL have ports rd_start in 1 (pulse: begin weight stream), out_valid out 1, out_ready in 1, out_data out LANES*WIDTH (lane i at bits [i*WIDTH+:WIDTH]), out_last out 1.
REQ-009 SHALL have ports bias_out out WIDTH, loaded out 1, busy out 1, err out 1 (sticky).

Function
REQ-010 SHALL store weights as ROWS rows of LANES*WIDTH in synchronous-read RAM, bias in a separate WIDTH register.
REQ-011 SHALL implement FSM states EMPTY, LOADING, IDLE, STREAM.
REQ-012 EMPTY/IDLE + load_start -> LOADING; load pointer cleared to 0, loaded cleared same edge.
REQ-013 LOADING: load_ready=1; each load_valid&load_ready writes word k (k=0..DEPTH-1) to row k/LANES, lane k%LANES, then k increments; word k=DEPTH writes bias register.
REQ-014 After bias write -> IDLE, loaded=1 next cycle, load_ready=0; load_valid outside LOADING SHALL be ignored.
REQ-015 load_start during LOADING SHALL restart pointer at 0; during STREAM SHALL be ignored and set err.
REQ-016 IDLE + rd_start -> STREAM; rd_start in EMPTY or LOADING SHALL be ignored and set err; in STREAM ignored without err.
REQ-017 STREAM: out_valid rises exactly 1 cycle after accepted rd_start carrying row 0 (read latency 1).
REQ-018 SHALL sustain one beat per cycle: RAM address each cycle = row_ptr+1 when out_valid&out_ready else row_ptr; out_data/out_valid held stable while out_valid&!out_ready.
REQ-019 out_last=1 only with row ROWS-1; handshake on last beat -> IDLE, out_valid/out_last=0 next cycle.
REQ-020 bias_out SHALL equal bias register continuously; valid when loaded=1.
REQ-021 busy=1 in LOADING or STREAM, else 0.
REQ-022 err SHALL clear only on rst; never self-clears.
REQ-023 LANES=1 SHALL be legal and degrade to one weight per beat; ROWS=1 SHALL assert out_last on the first beat.

Reset
REQ-024 rst SHALL force EMPTY; load_ready, out_valid, out_last, loaded, busy, err=0; out_data, bias_out=0.
REQ-025 RAM contents SHALL NOT be cleared by rst; loaded=0 forces reload before streaming.
REQ-026 rst mid-LOADING or mid-STREAM SHALL abort at that edge with REQ-024 outputs next cycle.

Verification
REQ-027 DEPTH=8, LANES=2: load words 0x0001..0x0008 then bias 0x4000 -> loaded=1, bias_out=0x4000, load_ready=0.
REQ-028 Same load, rd_start, out_ready=1 -> 4 consecutive beats {0x0002,0x0001},{0x0004,0x0003},{0x0006,0x0005},{0x0008,0x0007} (lane1,lane0), out_last on beat 4 only.
REQ-029 Stream with out_ready toggling 1,0,0,1,... -> out_data stable while stalled, no beat lost or duplicated, 4 beats total.
REQ-030 rd_start before any load -> no out_valid, err=1; load_start mid-STREAM -> stream completes unchanged, err=1.
REQ-031 rst after 3 beats of stream -> out_valid=0, loaded=0 next cycle; rd_start ignored until full reload.
REQ-032 load_start after loading 5 words -> pointer restarts; 9 new words give new weights/bias, no residue of partial load.
